// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the 8-bit LFSR generator and checker: word width,
// feedback tap mask, checker FSM state encoding and a popcount helper.
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;

  // Bits (besides bit 0) that receive the feedback term after the left shift.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0110_0010;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lfsr_state_t;

  // Number of set bits in an LFSR-wide word (0..8).
  function automatic logic [3:0] popcount8(input logic [LFSR_W-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < LFSR_W; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// -----------------------------------------------------------------------------
// lfsr_next
// Combinational next-state function of the 8-bit LFSR. The extra
// (S[6:0]==0) term in the feedback splices the all-zero state into the
// sequence, giving a full 256-state cycle.
// Ports:
//   i_s  input  [7:0]  current state
//   o_n  output [7:0]  next state
// -----------------------------------------------------------------------------
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_s,
  output logic [LFSR_W-1:0] o_n
);

  logic w_fb;

  assign w_fb = i_s[LFSR_W-1] ^ (i_s[LFSR_W-2:0] == {(LFSR_W-1){1'b0}});

  // Shift left, feed w_fb into bit 0 and XOR it into the tap positions.
  assign o_n = {i_s[LFSR_W-2:0], w_fb} ^ (LFSR_TAPS & {LFSR_W{w_fb}});

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Locks onto an incoming LFSR word stream and counts word/bit errors while
// locked. Unlocked: every valid word seeds the prediction; LOCK_CNT
// consecutive correct predictions declare lock. Locked: the prediction
// free-runs, so one corrupted word costs exactly one error; UNLOCK_CNT
// consecutive misses drop lock.
// Ports:
//   clk             input        clock, rising edge
//   i_rst_n         input        asynchronous active-low reset
//   i_valid         input        qualifies i_lfsr
//   i_lfsr          input  [7:0] received LFSR word
//   i_clr_cnt       input        synchronous clear of both error counters
//   o_lock          output       locked to incoming sequence
//   o_err           output       one-cycle pulse per locked mismatch
//   o_word_err_cnt  output [15:0] mismatching words while locked (saturating)
//   o_bit_err_cnt   output [15:0] mismatching bits while locked (saturating)
// -----------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [LFSR_W-1:0] i_lfsr,
  input  logic              i_clr_cnt,
  output logic              o_lock,
  output logic              o_err,
  output logic [15:0]       o_word_err_cnt,
  output logic [15:0]       o_bit_err_cnt
);

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_CNT);

  lfsr_state_t       r_state;
  logic [LFSR_W-1:0] r_pred;
  logic              r_pred_ok;
  logic [3:0]        r_match_cnt;
  logic [3:0]        r_miss_cnt;
  logic              r_lock;
  logic              r_err;
  logic [15:0]       r_word_cnt;
  logic [15:0]       r_bit_cnt;

  logic [LFSR_W-1:0] w_next_in;
  logic [LFSR_W-1:0] w_next_pred;
  logic              w_mismatch;
  logic [3:0]        w_bit_errs;
  logic [16:0]       w_bit_sum;
  logic [15:0]       w_bit_sat;
  logic [15:0]       w_word_sat;

  lfsr_next u_next_in (
    .i_s (i_lfsr),
    .o_n (w_next_in)
  );

  lfsr_next u_next_pred (
    .i_s (r_pred),
    .o_n (w_next_pred)
  );

  assign w_mismatch = (i_lfsr != r_pred);
  assign w_bit_errs = popcount8(i_lfsr ^ r_pred);
  // 17-bit sum so an overflowing bit increment saturates instead of wrapping.
  assign w_bit_sum  = {1'b0, r_bit_cnt} + {13'd0, w_bit_errs};
  assign w_bit_sat  = w_bit_sum[16] ? 16'hFFFF : w_bit_sum[15:0];
  assign w_word_sat = (r_word_cnt == 16'hFFFF) ? 16'hFFFF : (r_word_cnt + 16'd1);

  // Lock FSM, prediction register, error pulse and error counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_UNLOCKED;
      r_pred      <= {LFSR_W{1'b0}};
      r_pred_ok   <= 1'b0;
      r_match_cnt <= 4'd0;
      r_miss_cnt  <= 4'd0;
      r_lock      <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= 16'd0;
      r_bit_cnt   <= 16'd0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        case (r_state)
          ST_UNLOCKED: begin
            r_pred    <= w_next_in;
            r_pred_ok <= 1'b1;
            // The first sample after reset/unlock only seeds the prediction.
            if (r_pred_ok) begin
              if (!w_mismatch) begin
                if ((r_match_cnt + 4'd1) == LOCK_CNT_C) begin
                  r_state     <= ST_LOCKED;
                  r_lock      <= 1'b1;
                  r_match_cnt <= 4'd0;
                  r_miss_cnt  <= 4'd0;
                end else begin
                  r_match_cnt <= r_match_cnt + 4'd1;
                end
              end else begin
                r_match_cnt <= 4'd0;
              end
            end
          end
          ST_LOCKED: begin
            // Free-run so a corrupted input word does not disturb the prediction.
            r_pred <= w_next_pred;
            if (w_mismatch) begin
              r_err      <= 1'b1;
              r_word_cnt <= w_word_sat;
              r_bit_cnt  <= w_bit_sat;
              if ((r_miss_cnt + 4'd1) == UNLOCK_CNT_C) begin
                r_state     <= ST_UNLOCKED;
                r_lock      <= 1'b0;
                r_match_cnt <= 4'd0;
                r_miss_cnt  <= 4'd0;
                r_pred_ok   <= 1'b0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 4'd1;
              end
            end else begin
              r_miss_cnt <= 4'd0;
            end
          end
          default: begin
            r_state     <= ST_UNLOCKED;
            r_lock      <= 1'b0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_pred_ok   <= 1'b0;
          end
        endcase
      end
      // Clear wins over any increment made above in the same cycle.
      if (i_clr_cnt) begin
        r_word_cnt <= 16'd0;
        r_bit_cnt  <= 16'd0;
      end
    end
  end

  assign o_lock         = r_lock;
  assign o_err          = r_err;
  assign o_word_err_cnt = r_word_cnt;
  assign o_bit_err_cnt  = r_bit_cnt;

endmodule
